// File: rtl/pkt_drop_pkg.sv
// pkt_drop_pkg: FSM state type and header constants
// shared by the packet drop filter files.
package pkt_drop_pkg;

  typedef enum logic [1:0] {
    HEAD,
    FWD,
    DROP
  } pkt_state_e;

  localparam int ETYPE_OFS     = 12;
  localparam int IPVER_OFS     = 14;
  localparam int IPPROTO_OFS   = 23;
  localparam int UDP_DPORT_OFS = 36;

  localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

endpackage

// File: rtl/pkt_drop_filter_if.sv
// pkt_drop_filter_if: AXI-stream bundle with tuser_err,
// master drives the beat, slave returns tready.
interface pkt_drop_filter_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic                    tuser_err;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser_err,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser_err,
    output tready
  );
endinterface

// File: rtl/pkt_drop_match.sv
// pkt_drop_match: combinational head-beat classifier,
// flags drop-all or an IPv4 UDP frame to cfg_udp_dport.
module pkt_drop_match
  import pkt_drop_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  cfg_drop_all,
  input  logic                  cfg_match_en,
  input  logic [15:0]           cfg_udp_dport,
  output logic                  drop
);

  logic [15:0] etype;
  logic [15:0] dport;
  logic [7:0]  ver_ihl;
  logic [7:0]  proto;
  logic        is_udp;
  logic        unused_tdata;

  // pull header fields (network byte order) and decide
  always_comb begin
    etype   = {tdata[ETYPE_OFS*8 +: 8],
               tdata[(ETYPE_OFS+1)*8 +: 8]};
    ver_ihl = tdata[IPVER_OFS*8 +: 8];
    proto   = tdata[IPPROTO_OFS*8 +: 8];
    dport   = {tdata[UDP_DPORT_OFS*8 +: 8],
               tdata[(UDP_DPORT_OFS+1)*8 +: 8]};
    is_udp  = (etype == ETYPE_IPV4) &&
              (ver_ihl == IP_VER_IHL) &&
              (proto == IP_PROTO_UDP);
    drop    = cfg_drop_all ||
              (cfg_match_en && is_udp &&
               (dport == cfg_udp_dport));
  end

  // payload beyond the header is irrelevant here
  assign unused_tdata = ^tdata;

endmodule

// File: rtl/pkt_drop_filter.sv
// pkt_drop_filter: per-packet drop filter with a one-beat
// output register; stats built only with PKT_DROP_STATS_EN.
module pkt_drop_filter
  import pkt_drop_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic              axis_aclk,
  input  logic              axis_rst,
  pkt_drop_filter_if.slave  s_axis,
  pkt_drop_filter_if.master m_axis,
  input  logic              cfg_drop_all,
  input  logic              cfg_match_en,
  input  logic [15:0]       cfg_udp_dport,
  output logic [31:0]       stat_pkt_in,
  output logic [31:0]       stat_pkt_drop
);

  localparam int KW = DATA_WIDTH / 8;

  pkt_state_e state_q, state_d;

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [KW-1:0]         out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  out_err_q, out_err_d;

  logic hd_drop;
  logic out_free;
  logic s_rdy;
  logic s_fire;
  logic fwd_beat;

  pkt_drop_match #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_match (
    .tdata         (s_axis.tdata),
    .cfg_drop_all  (cfg_drop_all),
    .cfg_match_en  (cfg_match_en),
    .cfg_udp_dport (cfg_udp_dport),
    .drop          (hd_drop)
  );

  // packet FSM: tready, forward qualifier, next state
  always_comb begin
    state_d  = state_q;
    s_rdy    = 1'b0;
    fwd_beat = 1'b0;
    out_free = !out_vld_q || m_axis.tready;
    if (!axis_rst) begin
      unique case (state_q)
        HEAD: begin
          s_rdy    = out_free;
          fwd_beat = !hd_drop;
        end
        FWD: begin
          s_rdy    = out_free;
          fwd_beat = 1'b1;
        end
        DROP: begin
          s_rdy = 1'b1;
        end
        default: begin
          s_rdy = 1'b0;
        end
      endcase
    end
    s_fire = s_axis.tvalid && s_rdy;
    if (s_fire && s_axis.tlast) begin
      state_d = HEAD;
    end else if (s_fire && (state_q == HEAD)) begin
      state_d = hd_drop ? DROP : FWD;
    end
  end

  // output register: load forwarded beats, hold on stall
  always_comb begin
    out_vld_d  = out_vld_q && !m_axis.tready;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    out_err_d  = out_err_q;
    if (s_fire && fwd_beat) begin
      out_vld_d  = 1'b1;
      out_data_d = s_axis.tdata;
      out_keep_d = s_axis.tkeep;
      out_last_d = s_axis.tlast;
      out_err_d  = s_axis.tuser_err;
    end
  end

  // state and output flops, cleared by sync reset
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q    <= HEAD;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      out_err_q  <= out_err_d;
    end
  end

  assign s_axis.tready    = s_rdy;
  assign m_axis.tvalid    = out_vld_q;
  assign m_axis.tdata     = out_data_q;
  assign m_axis.tkeep     = out_keep_q;
  assign m_axis.tlast     = out_last_q;
  assign m_axis.tuser_err = out_err_q;

`ifdef PKT_DROP_STATS_EN
  logic [31:0] pkt_in_q, pkt_in_d;
  logic [31:0] pkt_drop_q, pkt_drop_d;
  logic        head_fire;

  // saturating counters bumped on each accepted head
  always_comb begin
    head_fire  = s_fire && (state_q == HEAD);
    pkt_in_d   = pkt_in_q;
    pkt_drop_d = pkt_drop_q;
    if (head_fire && (pkt_in_q != '1)) begin
      pkt_in_d = pkt_in_q + 32'd1;
    end
    if (head_fire && hd_drop && (pkt_drop_q != '1)) begin
      pkt_drop_d = pkt_drop_q + 32'd1;
    end
  end

  // counter flops
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      pkt_in_q   <= '0;
      pkt_drop_q <= '0;
    end else begin
      pkt_in_q   <= pkt_in_d;
      pkt_drop_q <= pkt_drop_d;
    end
  end

  assign stat_pkt_in   = pkt_in_q;
  assign stat_pkt_drop = pkt_drop_q;
`else
  assign stat_pkt_in   = '0;
  assign stat_pkt_drop = '0;
`endif

endmodule

// File: tb/tb_pkt_drop_filter.sv
// tb_pkt_drop_filter: random and directed stimulus checked
// against a packet-level reference model.
module tb_pkt_drop_filter;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    bit           l;
    bit           e;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        cfg_drop_all;
  logic        cfg_match_en;
  logic [15:0] cfg_udp_dport;
  logic [31:0] stat_pkt_in;
  logic [31:0] stat_pkt_drop;

  pkt_drop_filter_if #(.DATA_WIDTH(512)) s_if ();
  pkt_drop_filter_if #(.DATA_WIDTH(512)) m_if ();

  pkt_drop_filter #(
    .DATA_WIDTH (512)
  ) dut (
    .axis_aclk     (clk),
    .axis_rst      (rst),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .cfg_drop_all  (cfg_drop_all),
    .cfg_match_en  (cfg_match_en),
    .cfg_udp_dport (cfg_udp_dport),
    .stat_pkt_in   (stat_pkt_in),
    .stat_pkt_drop (stat_pkt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_tot = 0;
  int fwd_out = 0;
  int vprob = 100;
  int rmode = 0;
  bit cfg_rand = 0;

  beat_t tx_q[$];
  beat_t exp_q[$];
  beat_t lat_b;
  beat_t st_b;
  bit    lat_pend = 0;
  bit    stall = 0;
  bit    acc_pend = 0;
  bit    hold = 0;
  bit    in_pkt = 0;
  bit    cur_drop = 0;
  logic [31:0] m_in = 0;
  logic [31:0] m_drop = 0;

  task automatic chk(string tag, logic [511:0] got,
                     logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [511:0] set_hdr(
    logic [511:0] d, logic [7:0] proto, logic [15:0] port);
    d[12*8 +: 8] = 8'h08;
    d[13*8 +: 8] = 8'h00;
    d[14*8 +: 8] = 8'h45;
    d[23*8 +: 8] = proto;
    d[36*8 +: 8] = port[15:8];
    d[37*8 +: 8] = port[7:0];
    return d;
  endfunction

  // reference rule, written straight from the byte layout
  function automatic bit exp_drop(logic [511:0] d, bit all,
                                  bit en, logic [15:0] port);
    logic [7:0] b [64];
    bit udp;
    int dp;
    for (int i = 0; i < 64; i++) b[i] = d[8*i +: 8];
    udp = (b[12] == 8'h08) && (b[13] == 8'h00) &&
          (b[14] == 8'h45) && (b[23] == 8'h11);
    dp = int'(b[36]) * 256 + int'(b[37]);
    return all || (en && udp && (dp == int'(port)));
  endfunction

  // kind: 0 raw, 1 udp, 2 tcp
  task automatic add_pkt(int nb, int kind, logic [15:0] port,
                         bit all_hdr, bit full_last);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.d = rnd512();
      if (kind != 0 && (i == 0 || all_hdr))
        b.d = set_hdr(b.d, (kind == 1) ? 8'h11 : 8'h06, port);
      b.l = (i == nb - 1);
      b.k = 64'hFFFF_FFFF_FFFF_FFFF;
      if (b.l && !full_last) b.k = b.k >> $urandom_range(0, 63);
      b.e = ($urandom_range(0, 3) == 0);
      tx_q.push_back(b);
    end
  endtask

  task automatic observe();
    bit exp_rdy;
    beat_t b;
    if (rst) begin
      chk("rst_rdy", 512'(s_if.tready), 512'(0));
      exp_q.delete();
      lat_pend = 0;
      stall = 0;
      acc_pend = 0;
      in_pkt = 0;
      m_in = 0;
      m_drop = 0;
      return;
    end
    chk("vld", 512'(m_if.tvalid), 512'(exp_q.size() != 0));
    if (lat_pend) begin
      chk("lat_data", m_if.tdata, lat_b.d);
      lat_pend = 0;
    end
    if (stall) begin
      chk("hold_data", m_if.tdata, st_b.d);
      chk("hold_ctl",
          512'({m_if.tvalid, m_if.tlast, m_if.tuser_err, m_if.tkeep}),
          512'({1'b1, st_b.l, st_b.e, st_b.k}));
    end
    exp_rdy = (in_pkt && cur_drop) ? 1'b1 :
              (exp_q.size() == 0 || m_if.tready);
    chk("s_rdy", 512'(s_if.tready), 512'(exp_rdy));
    if (m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 512'(1), 512'(0));
      end else begin
        b = exp_q.pop_front();
        chk("out_data", m_if.tdata, b.d);
        chk("out_ctl",
            512'({m_if.tlast, m_if.tuser_err, m_if.tkeep}),
            512'({b.l, b.e, b.k}));
        fwd_out++;
      end
    end
    stall = m_if.tvalid && !m_if.tready;
    st_b.d = m_if.tdata;
    st_b.k = m_if.tkeep;
    st_b.l = m_if.tlast;
    st_b.e = m_if.tuser_err;
    acc_pend = s_if.tvalid && s_if.tready;
    if (acc_pend) begin
      b = tx_q[0];
      acc_tot++;
      if (!in_pkt) begin
        cur_drop = exp_drop(b.d, cfg_drop_all, cfg_match_en,
                            cfg_udp_dport);
        if (m_in != 32'hFFFF_FFFF) m_in++;
        if (cur_drop && m_drop != 32'hFFFF_FFFF) m_drop++;
      end
      in_pkt = !b.l;
      if (!cur_drop) begin
        exp_q.push_back(b);
        lat_pend = 1;
        lat_b = b;
      end
    end
  endtask

  task automatic drive();
    int r;
    rst = 1'b0;
    if (acc_pend) begin
      tx_q.delete(0);
      hold = 0;
    end
    if (tx_q.size() != 0 &&
        (hold || $urandom_range(0, 99) < vprob)) begin
      s_if.tvalid    = 1'b1;
      s_if.tdata     = tx_q[0].d;
      s_if.tkeep     = tx_q[0].k;
      s_if.tlast     = tx_q[0].l;
      s_if.tuser_err = tx_q[0].e;
      hold = 1;
    end else begin
      s_if.tvalid = 1'b0;
    end
    case (rmode)
      0: m_if.tready = 1'b1;
      1: m_if.tready = ($urandom_range(0, 99) < 70);
      default: m_if.tready = (cyc % 3 == 0);
    endcase
    if (cfg_rand && $urandom_range(0, 99) < 5) begin
      cfg_drop_all = ($urandom_range(0, 99) < 15);
      cfg_match_en = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1);
      cfg_udp_dport = (r == 0) ? 16'h04D2 : 16'h04D3;
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_acc(int target);
    int n = 0;
    while (acc_tot < target && n < 500) begin
      cycle();
      n++;
    end
    chk("acc_timeout", 512'(acc_tot), 512'(target));
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 512'(tx_q.size() + exp_q.size()), 512'(0));
    repeat (2) cycle();
  endtask

  task automatic chk_stats(string t);
`ifdef PKT_DROP_STATS_EN
    chk({t, "_in"}, 512'(stat_pkt_in), 512'(m_in));
    chk({t, "_drop"}, 512'(stat_pkt_drop), 512'(m_drop));
`else
    chk({t, "_in"}, 512'(stat_pkt_in), 512'(0));
    chk({t, "_drop"}, 512'(stat_pkt_drop), 512'(0));
`endif
  endtask

  initial begin
    int k;
    int p;
    rst = 1'b1;
    cfg_drop_all = 1'b0;
    cfg_match_en = 1'b0;
    cfg_udp_dport = 16'h0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tlast = 1'b0;
    s_if.tuser_err = 1'b0;
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_rdy", 512'(s_if.tready), 512'(0));
    chk("rst_m_vld", 512'(m_if.tvalid), 512'(0));
    chk("rst_m_data", m_if.tdata, 512'(0));
    chk("rst_m_ctl",
        512'({m_if.tlast, m_if.tuser_err, m_if.tkeep}), 512'(0));
    chk("rst_st_in", 512'(stat_pkt_in), 512'(0));
    chk("rst_st_drop", 512'(stat_pkt_drop), 512'(0));
    @(posedge clk);
    #1;
    drive();

    // drop-all on a full 1-beat packet, then a long idle
    cfg_drop_all = 1'b1;
    add_pkt(1, 1, 16'h1234, 0, 1);
    drain();
    repeat (1000) cycle();
    chk("drop1_out", 512'(fwd_out), 512'(0));
    chk_stats("drop1");

    // UDP port match drops, neighbouring port forwards
    cfg_drop_all = 1'b0;
    cfg_match_en = 1'b1;
    cfg_udp_dport = 16'h04D2;
    add_pkt(3, 1, 16'h04D2, 0, 0);
    drain();
    chk("udp_hit_out", 512'(fwd_out), 512'(0));
    chk_stats("udp_hit");
    add_pkt(3, 1, 16'h04D3, 0, 0);
    drain();
    chk("udp_miss_out", 512'(fwd_out), 512'(3));
    chk_stats("udp_miss");

    // 1,0,0 ready pattern under a 4-beat packet
    rmode = 2;
    fwd_out = 0;
    add_pkt(4, 2, 16'h04D2, 0, 0);
    drain();
    chk("bp_out", 512'(fwd_out), 512'(4));
    rmode = 0;

    // drop-all raised on beat 2 affects only next packet
    fwd_out = 0;
    cfg_match_en = 1'b0;
    add_pkt(4, 0, 16'h0, 0, 0);
    add_pkt(2, 0, 16'h0, 0, 0);
    run_until_acc(acc_tot + 1);
    cfg_drop_all = 1'b1;
    drain();
    chk("midcfg_out", 512'(fwd_out), 512'(4));
    chk_stats("midcfg");

    // reset during beat 2; beat 3 then acts as a head
    cfg_drop_all = 1'b0;
    fwd_out = 0;
    add_pkt(4, 1, 16'h0777, 1, 0);
    run_until_acc(acc_tot + 2);
    cfg_match_en = 1'b1;
    cfg_udp_dport = 16'h0777;
    rst = 1'b1;
    cycle();
    chk("rst_mid_vld", 512'(m_if.tvalid), 512'(0));
    drain();
    chk_stats("rst_mid");

    // randomized traffic, config and backpressure
    rmode = 1;
    vprob = 70;
    cfg_rand = 1;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 2);
      p = $urandom_range(0, 2);
      add_pkt($urandom_range(1, 5), k,
              (p == 0) ? 16'h04D2 : (p == 1) ? 16'h04D3 :
              16'($urandom), 0, $urandom_range(0, 1) == 1);
    end
    drain();
    chk_stats("rand");
    cfg_rand = 0;
    vprob = 100;
    rmode = 0;

`ifdef PKT_DROP_STATS_EN
    // counter saturation from a preloaded value
    force dut.pkt_in_q = 32'hFFFF_FFFE;
    cycle();
    release dut.pkt_in_q;
    m_in = 32'hFFFF_FFFE;
    chk("sat_pre", 512'(stat_pkt_in), 512'(32'hFFFF_FFFE));
    cfg_drop_all = 1'b0;
    for (int i = 0; i < 3; i++) add_pkt(2, 0, 16'h0, 0, 1);
    drain();
    chk("sat_in", 512'(stat_pkt_in), 512'(32'hFFFF_FFFF));
    chk_stats("sat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule
